// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, functs, datapath select codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXECUTE,
        S_ALUWB, S_BRANCH, S_IMMEX, S_IMMWB, S_JUMP, S_FAULT
    } state_e;

    // Which ALU operation source a state wants; mc_aludec resolves it to a code.
    typedef enum logic [2:0] {AC_NONE, AC_ADD, AC_SUB, AC_FUNCT, AC_IMM} alu_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLE   = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [3:0] ALUC_ADD  = 4'b0010;
    localparam logic [3:0] ALUC_SUB  = 4'b0110;
    localparam logic [3:0] ALUC_AND  = 4'b0000;
    localparam logic [3:0] ALUC_OR   = 4'b0001;
    localparam logic [3:0] ALUC_SLT  = 4'b0111;
    localparam logic [3:0] ALUC_SLTU = 4'b1111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    typedef struct packed {
        logic       memreq;
        logic       memwrite;
        logic       iord;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic       fault;
    } ctrl_t;

    function automatic logic is_mem_wait(input state_e s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: maps the requesting state's ALU class plus op/funct to an alucontrol code.
// Latency: purely combinational.
// Backpressure: none; funct_vld flags an unsupported R-type funct.
module mc_aludec
    import mips_pkg::*;
(
    input  alu_class_e alu_class,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [3:0] alucontrol,
    output logic       funct_vld
);

    always_comb begin
        alucontrol = ALUC_AND;
        funct_vld  = 1'b0;
        case (alu_class)
            AC_ADD: alucontrol = ALUC_ADD;
            AC_SUB: alucontrol = ALUC_SUB;
            AC_IMM: alucontrol = (op == OP_SLTI) ? ALUC_SLT : ALUC_ADD;
            AC_FUNCT: begin
                funct_vld = 1'b1;
                case (funct)
                    FN_ADD:  alucontrol = ALUC_ADD;
                    FN_SUB:  alucontrol = ALUC_SUB;
                    FN_AND:  alucontrol = ALUC_AND;
                    FN_OR:   alucontrol = ALUC_OR;
                    FN_SLT:  alucontrol = ALUC_SLT;
                    FN_SLTU: alucontrol = ALUC_SLTU;
                    default: funct_vld = 1'b0;
                endcase
            end
            default: alucontrol = ALUC_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM with memory wait-state timeout and sticky fault state.
// Latency: 3-5 cycles per instruction plus memory wait states.
// Backpressure: memory states hold until memready, faulting after MEM_TIMEOUT idle cycles.
module multicycle_controller
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       aluneg,
    input  logic       memready,
    output logic       memreq,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [3:0] alucontrol,
    output logic       pcen,
    output logic       fault
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    alu_class_e alu_class;
    logic       funct_vld;
    logic       timeout;
    logic       br_taken;
    ctrl_t      c;

    mc_aludec u_aludec (
        .alu_class  (alu_class),
        .op         (op),
        .funct      (funct),
        .alucontrol (alucontrol),
        .funct_vld  (funct_vld)
    );

    // memready on the last allowed cycle still counts as a normal completion.
    assign timeout  = is_mem_wait(state_q) && !memready && (cnt_q == CW'(MEM_TIMEOUT - 1));
    assign br_taken = ((op == OP_BEQ) && zero) || ((op == OP_BNE) && !zero) ||
                      ((op == OP_BLE) && (zero || aluneg));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   state_d = memready ? S_DECODE : (timeout ? S_FAULT : S_FETCH);
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW:          state_d = S_MEMADR;
                    OP_RTYPE:              state_d = S_EXECUTE;
                    OP_BEQ, OP_BNE, OP_BLE: state_d = S_BRANCH;
                    OP_ADDI, OP_SLTI:      state_d = S_IMMEX;
                    OP_J:                  state_d = S_JUMP;
                    default:               state_d = S_FAULT;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : ((op == OP_SW) ? S_MEMWR : S_FAULT);
            S_MEMRD:   state_d = memready ? S_MEMWB : (timeout ? S_FAULT : S_MEMRD);
            S_MEMWR:   state_d = memready ? S_FETCH : (timeout ? S_FAULT : S_MEMWR);
            S_EXECUTE: state_d = funct_vld ? S_ALUWB : S_FAULT;
            S_IMMEX:   state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_IMMWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
            S_FAULT:   state_d = S_FAULT;
            default:   state_d = S_FAULT;
        endcase
        // Any transition (including entry into a wait state) restarts the count.
        cnt_d = (is_mem_wait(state_q) && (state_d == state_q)) ? cnt_q + CW'(1) : '0;
    end

    always_comb begin
        c         = '0;
        alu_class = AC_NONE;
        case (state_q)
            S_FETCH: begin
                c.memreq  = 1'b1;
                c.alusrcb = SRCB_FOUR;
                c.pcsrc   = PCSRC_ALU;
                c.irwrite = memready;
                c.pcen    = memready;
                alu_class = AC_ADD;
            end
            S_DECODE: begin
                c.alusrcb = SRCB_IMMSH;
                alu_class = AC_ADD;
            end
            S_MEMADR: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                alu_class = AC_ADD;
            end
            S_MEMRD: begin
                c.memreq = 1'b1;
                c.iord   = 1'b1;
            end
            S_MEMWB: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            S_MEMWR: begin
                c.memreq   = 1'b1;
                c.memwrite = 1'b1;
                c.iord     = 1'b1;
            end
            S_EXECUTE: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                alu_class = AC_FUNCT;
            end
            S_ALUWB: begin
                c.regdst   = 1'b1;
                c.regwrite = 1'b1;
            end
            S_BRANCH: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_REG;
                c.pcsrc   = PCSRC_ALUOUT;
                c.pcen    = br_taken;
                alu_class = AC_SUB;
            end
            S_IMMEX: begin
                c.alusrca = 1'b1;
                c.alusrcb = SRCB_IMM;
                alu_class = AC_IMM;
            end
            S_IMMWB:  c.regwrite = 1'b1;
            S_JUMP: begin
                c.pcsrc = PCSRC_JUMP;
                c.pcen  = 1'b1;
            end
            S_FAULT:  c.fault = 1'b1;
            default:  c.fault = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset sits in FETCH, so side-effecting enables are masked while it is held.
    assign memreq   = c.memreq & reset;
    assign memwrite = c.memwrite & reset;
    assign irwrite  = c.irwrite & reset;
    assign regwrite = c.regwrite & reset;
    assign pcen     = c.pcen & reset;
    assign iord     = c.iord;
    assign regdst   = c.regdst;
    assign memtoreg = c.memtoreg;
    assign alusrca  = c.alusrca;
    assign alusrcb  = c.alusrcb;
    assign pcsrc    = c.pcsrc;
    assign fault    = c.fault;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle vector table plus timeout, fault and reset sequences.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       aluneg = 1'b0;
    logic       memready = 1'b0;
    logic       memreq, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] alucontrol;
    logic       pcen, fault;

    int total = 0;
    int bad = 0;

    multicycle_controller #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .aluneg(aluneg),
        .memready(memready), .memreq(memreq), .memwrite(memwrite), .iord(iord),
        .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol),
        .pcen(pcen), .fault(fault)
    );

    always #5 clk = ~clk;

    // Bit order: memreq,memwrite,iord,irwrite,regdst,memtoreg,regwrite,alusrca,alusrcb,pcsrc,alucontrol,pcen,fault
    logic [17:0] act;
    assign act = {memreq, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca,
                  alusrcb, pcsrc, alucontrol, pcen, fault};

    localparam logic [17:0] MASK_ALL = 18'h3FFFF;
    // memreq, memwrite, irwrite, regwrite, pcen, fault
    localparam logic [17:0] MASK_RST = {8'b1101_0010, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b1};

    function automatic logic [17:0] mk(input logic [7:0] en, input logic [1:0] srcb,
                                       input logic [1:0] pcs, input logic [3:0] alu,
                                       input logic pc, input logic flt);
        return {en, srcb, pcs, alu, pc, flt};
    endfunction

    function automatic logic [17:0] e_fetch(input logic mr);
        return mk({1'b1, 1'b0, 1'b0, mr, 4'b0000}, 2'b01, 2'b00, 4'b0010, mr, 1'b0);
    endfunction

    localparam logic [17:0] E_DECODE = {8'b0000_0000, 2'b11, 2'b00, 4'b0010, 1'b0, 1'b0};
    localparam logic [17:0] E_ALUWB  = {8'b0000_1010, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMADR = {8'b0000_0001, 2'b10, 2'b00, 4'b0010, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMRD  = {8'b1010_0000, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMWB  = {8'b0000_0110, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0};
    localparam logic [17:0] E_MEMWR  = {8'b1110_0000, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0};
    localparam logic [17:0] E_IMMWB  = {8'b0000_0010, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0};
    localparam logic [17:0] E_JUMP   = {8'b0000_0000, 2'b00, 2'b10, 4'b0000, 1'b1, 1'b0};
    localparam logic [17:0] E_FAULT  = {8'b0000_0000, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1};
    localparam logic [17:0] E_RESET  = 18'h0;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic        aluneg;
        logic        memready;
        logic [17:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add_v(input logic [5:0] o, input logic [5:0] f, input logic z,
                         input logic n, input logic mr, input logic [17:0] e);
        vec_t v;
        v.op = o; v.funct = f; v.zero = z; v.aluneg = n; v.memready = mr; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic add_rtype(input logic [5:0] f, input logic [3:0] alu);
        add_v(6'b000000, f, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add_v(6'b000000, f, 1'b0, 1'b0, 1'b0, E_DECODE);
        add_v(6'b000000, f, 1'b0, 1'b0, 1'b0, mk(8'b0000_0001, 2'b00, 2'b00, alu, 1'b0, 1'b0));
        add_v(6'b000000, f, 1'b0, 1'b0, 1'b0, E_ALUWB);
    endtask

    task automatic add_branch(input logic [5:0] o, input logic z, input logic n, input logic taken);
        add_v(o, 6'b0, z, n, 1'b1, e_fetch(1'b1));
        add_v(o, 6'b0, z, n, 1'b0, E_DECODE);
        add_v(o, 6'b0, z, n, 1'b0, mk(8'b0000_0001, 2'b00, 2'b01, 4'b0110, taken, 1'b0));
    endtask

    task automatic add_imm(input logic [5:0] o, input logic [3:0] alu);
        add_v(o, 6'b0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add_v(o, 6'b0, 1'b0, 1'b0, 1'b0, E_DECODE);
        add_v(o, 6'b0, 1'b0, 1'b0, 1'b0, mk(8'b0000_0001, 2'b10, 2'b00, alu, 1'b0, 1'b0));
        add_v(o, 6'b0, 1'b0, 1'b0, 1'b0, E_IMMWB);
    endtask

    task automatic check(input string nm, input logic [17:0] a, input logic [17:0] e,
                         input logic [17:0] m);
        total++;
        if ((a & m) !== (e & m)) begin
            bad++;
            $display("FAIL %s: got %b required %b (mask %b)", nm, a, e, m);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge, releasing reset if held.
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic z,
                        input logic n, input logic mr);
        @(negedge clk);
        reset = 1'b1;
        op = o; funct = f; zero = z; aluneg = n; memready = mr;
        #2;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b0;
        memready = 1'b0;
        #2;
        check(nm, act, E_RESET, MASK_RST);
    endtask

    initial begin
        int regwrite_cnt;
        // ---------------- vector table ----------------
        add_rtype(6'b100000, 4'b0010);
        add_rtype(6'b100010, 4'b0110);
        add_rtype(6'b100100, 4'b0000);
        add_rtype(6'b100101, 4'b0001);
        add_rtype(6'b101010, 4'b0111);
        add_rtype(6'b101011, 4'b1111);
        // LW with three wait cycles in MEMRD: 8 cycles
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, E_DECODE);
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, E_MEMADR);
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, E_MEMRD);
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, E_MEMRD);
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, E_MEMRD);
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b1, E_MEMRD);
        add_v(6'b100011, 6'b0, 1'b0, 1'b0, 1'b0, E_MEMWB);
        // SW
        add_v(6'b101011, 6'b0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add_v(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, E_DECODE);
        add_v(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0, E_MEMADR);
        add_v(6'b101011, 6'b0, 1'b0, 1'b0, 1'b1, E_MEMWR);
        // branches
        add_branch(6'b000111, 1'b0, 1'b1, 1'b1);
        add_branch(6'b000101, 1'b1, 1'b0, 1'b0);
        add_branch(6'b000100, 1'b1, 1'b0, 1'b1);
        add_branch(6'b000100, 1'b0, 1'b0, 1'b0);
        add_branch(6'b000101, 1'b0, 1'b1, 1'b1);
        add_branch(6'b000111, 1'b0, 1'b0, 1'b0);
        add_branch(6'b000111, 1'b1, 1'b0, 1'b1);
        add_imm(6'b001000, 4'b0010);
        add_imm(6'b001010, 4'b0111);
        // J
        add_v(6'b000010, 6'b0, 1'b0, 1'b0, 1'b1, e_fetch(1'b1));
        add_v(6'b000010, 6'b0, 1'b0, 1'b0, 1'b0, E_DECODE);
        add_v(6'b000010, 6'b0, 1'b0, 1'b0, 1'b0, E_JUMP);
        // trailing FETCH proves JUMP returned to FETCH
        add_v(6'b000000, 6'b0, 1'b0, 1'b0, 1'b0, e_fetch(1'b0));

        do_reset("reset_initial");
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].aluneg, tbl[i].memready);
            check($sformatf("vec%0d", i), act, tbl[i].exp, MASK_ALL);
        end

        // ---------------- LW regwrite/memtoreg pulse count ----------------
        do_reset("reset_lw");
        regwrite_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(6'b100011, 6'b0, 1'b0, 1'b0, (i == 0 || i == 6) ? 1'b1 : 1'b0);
            if (regwrite && memtoreg) regwrite_cnt++;
        end
        total++;
        if (regwrite_cnt != 1) begin
            bad++;
            $display("FAIL lw_wb_count: got %0d required 1", regwrite_cnt);
        end

        // ---------------- illegal opcode -> sticky fault ----------------
        do_reset("reset_fault");
        step(6'b111111, 6'b0, 1'b0, 1'b0, 1'b1);
        check("fault_fetch", act, e_fetch(1'b1), MASK_ALL);
        step(6'b111111, 6'b0, 1'b0, 1'b0, 1'b0);
        check("fault_decode", act, E_DECODE, MASK_ALL);
        for (int i = 0; i < 20; i++) begin
            step(6'b111111, 6'b0, 1'b1, 1'b1, 1'b1);
            check($sformatf("fault_hold%0d", i), act, E_FAULT, MASK_ALL);
        end
        #1 reset = 1'b0;
        #1 check("fault_reset_clears", act, E_RESET, MASK_RST);
        step(6'b000000, 6'b0, 1'b0, 1'b0, 1'b0);
        check("fault_recover_fetch", act, e_fetch(1'b0), MASK_ALL);

        // ---------------- FETCH timeout ----------------
        do_reset("reset_to");
        for (int i = 1; i <= 15; i++) begin
            step(6'b000000, 6'b0, 1'b0, 1'b0, 1'b0);
            check($sformatf("to_wait%0d", i), act, e_fetch(1'b0), MASK_ALL);
        end
        step(6'b000000, 6'b0, 1'b0, 1'b0, 1'b0);
        check("to_fault", act, E_FAULT, MASK_ALL);

        // memready on the 15th cycle completes normally
        do_reset("reset_to_edge");
        for (int i = 1; i <= 14; i++)
            step(6'b000000, 6'b0, 1'b0, 1'b0, 1'b0);
        step(6'b000000, 6'b0, 1'b0, 1'b0, 1'b1);
        check("to_edge_fetch", act, e_fetch(1'b1), MASK_ALL);
        step(6'b000000, 6'b0, 1'b0, 1'b0, 1'b0);
        check("to_edge_decode", act, E_DECODE, MASK_ALL);

        // ---------------- reset mid-MEMWR ----------------
        do_reset("reset_sw");
        step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b1);
        step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0);
        step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0);
        step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0);
        check("sw_memwr", act, E_MEMWR, MASK_ALL);
        #1 reset = 1'b0;
        #1 check("sw_reset_drop", act, E_RESET, MASK_RST);
        step(6'b101011, 6'b0, 1'b0, 1'b0, 1'b0);
        check("sw_after_reset_fetch", act, e_fetch(1'b0), MASK_ALL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
